// File: rtl/mlcd_pkg.sv
// Shared definitions for the MIPI-style 8080 LCD responder: command opcodes,
// controller states and the window-limit clamp helper.
package mlcd_pkg;

  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_RDID    = 8'hD3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_RDID
  } state_t;

  function automatic logic [9:0] clamp_lim(input logic [15:0] v, input logic [15:0] lim);
    return 10'((v > lim) ? lim : v);
  endfunction

endpackage

// File: rtl/mlcd_sync.sv
// Two-flop synchronizer for one active-low host strobe plus a change detect
// stage; idles high so a reset never produces a spurious edge.
module mlcd_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic changed
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= pin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level   = s2;
  assign changed = s2 ^ s3;

endmodule

// File: rtl/mlcd_resp.sv
// 8080-bus LCD controller responder: window/cursor tracking and pixel stream
// output. Define MLCD_READ_EN to enable the read-ID (0xD3) bus read path.
module mlcd_resp
  import mlcd_pkg::*;
#(
  parameter int          H_RES   = 240,
  parameter int          V_RES   = 320,
  parameter logic [15:0] ID_CODE = 16'h9341
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        mlcd_cs_n,
  input  logic        mlcd_wr_n,
  input  logic        mlcd_rd_n,
  input  logic        mlcd_rs,
  input  logic [15:0] mlcd_data_in,
  output logic [15:0] mlcd_data_out,
  output logic        mlcd_data_oe,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        disp_on,
  output logic        pix_ovf
);

  localparam logic [15:0] X_MAX = 16'(H_RES - 1);
  localparam logic [15:0] Y_MAX = 16'(V_RES - 1);

  logic cs_lvl, cs_chg, wr_lvl, wr_chg, rd_lvl, rd_chg;

  mlcd_sync u_cs_sync (.clk(sys_clk), .rst(sys_rst), .pin(mlcd_cs_n), .level(cs_lvl), .changed(cs_chg));
  mlcd_sync u_wr_sync (.clk(sys_clk), .rst(sys_rst), .pin(mlcd_wr_n), .level(wr_lvl), .changed(wr_chg));
  mlcd_sync u_rd_sync (.clk(sys_clk), .rst(sys_rst), .pin(mlcd_rd_n), .level(rd_lvl), .changed(rd_chg));

  // A strobe edge only counts while chip-select and the opposite strobe are
  // settled; a write finishing while rd_n is low is the both-low conflict.
  logic wr_ev;
  assign wr_ev = wr_chg & wr_lvl & ~cs_lvl & ~cs_chg & rd_lvl & ~rd_chg;

  state_t      state;
  logic [1:0]  pcnt;
  logic [7:0]  hi_byte;
  logic [9:0]  start_tmp;
  logic [9:0]  sc, ec, sp, ep;
  logic [9:0]  cur_x, cur_y;
  logic [15:0] param_lim;
  logic [9:0]  param_val;

  assign param_lim = (state == ST_CASET) ? X_MAX : Y_MAX;
  assign param_val = clamp_lim({hi_byte, mlcd_data_in[7:0]}, param_lim);

`ifdef MLCD_READ_EN
  logic rd_ev;
  assign rd_ev = rd_chg & ~rd_lvl & ~cs_lvl & ~cs_chg & wr_lvl & ~wr_chg;
`else
  assign mlcd_data_out = '0;
  assign mlcd_data_oe  = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      pcnt      <= '0;
      hi_byte   <= '0;
      start_tmp <= '0;
      sc        <= '0;
      sp        <= '0;
      ec        <= X_MAX[9:0];
      ep        <= Y_MAX[9:0];
      cur_x     <= '0;
      cur_y     <= '0;
      pix_valid <= 1'b0;
      pix_ovf   <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_data  <= '0;
      disp_on   <= 1'b0;
`ifdef MLCD_READ_EN
      mlcd_data_oe  <= 1'b0;
      mlcd_data_out <= '0;
`endif
    end else begin
      if (pix_valid && pix_ready)
        pix_valid <= 1'b0;

      if (wr_ev && !mlcd_rs) begin
        pcnt <= '0;
        case (mlcd_data_in[7:0])
          CMD_CASET: state <= ST_CASET;
          CMD_PASET: state <= ST_PASET;
          CMD_RAMWR: begin
            state <= ST_RAMWR;
            cur_x <= sc;
            cur_y <= sp;
          end
          CMD_DISPON: begin
            disp_on <= 1'b1;
            state   <= ST_IDLE;
          end
          CMD_DISPOFF: begin
            disp_on <= 1'b0;
            state   <= ST_IDLE;
          end
`ifdef MLCD_READ_EN
          CMD_RDID: state <= ST_RDID;
`endif
          default: state <= ST_IDLE;
        endcase
      end else if (wr_ev) begin
        case (state)
          ST_CASET, ST_PASET: begin
            pcnt <= pcnt + 2'd1;
            case (pcnt)
              2'd0, 2'd2: hi_byte <= mlcd_data_in[7:0];
              2'd1:       start_tmp <= param_val;
              default: begin
                // Window commits only on the last byte so an aborted
                // sequence leaves the previous window intact.
                if (state == ST_CASET) begin
                  sc <= start_tmp;
                  ec <= (start_tmp > param_val) ? start_tmp : param_val;
                end else begin
                  sp <= start_tmp;
                  ep <= (start_tmp > param_val) ? start_tmp : param_val;
                end
                state <= ST_IDLE;
              end
            endcase
          end
          ST_RAMWR: begin
            if (!pix_valid || pix_ready) begin
              pix_valid <= 1'b1;
              pix_x     <= cur_x;
              pix_y     <= cur_y;
              pix_data  <= mlcd_data_in;
            end else begin
              pix_ovf <= 1'b1;
            end
            if (cur_x == ec) begin
              cur_x <= sc;
              cur_y <= (cur_y == ep) ? sp : cur_y + 10'd1;
            end else begin
              cur_x <= cur_x + 10'd1;
            end
          end
          default: ;
        endcase
      end

`ifdef MLCD_READ_EN
      mlcd_data_oe <= ~cs_lvl & ~rd_lvl & wr_lvl;
      if (rd_ev && state == ST_RDID) begin
        case (pcnt)
          2'd2:    mlcd_data_out <= {8'h00, ID_CODE[15:8]};
          2'd3:    mlcd_data_out <= {8'h00, ID_CODE[7:0]};
          default: mlcd_data_out <= '0;
        endcase
        if (pcnt != 2'd3)
          pcnt <= pcnt + 2'd1;
      end
`endif
    end
  end

endmodule

// File: doc/mlcd_resp.md
MLCD_RESP -- requirements
Module: mlcd_resp

Interface
REQ-001 SHALL have parameter H_RES, default 240, panel column count.
REQ-002 SHALL have parameter V_RES, default 320, panel row count.
REQ-003 SHALL have parameter ID_CODE, default 16'h9341, value returned by the read-ID command.
REQ-004 Port sys_clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 Port sys_rst  in  1  reset, synchronous and active-high.
REQ-006 Port mlcd_cs_n, mlcd_wr_n, mlcd_rd_n, mlcd_rs  in  1 each  8080 host strobes, asynchronous to sys_clk.
REQ-007 Port mlcd_data_in  in  16  host bus data; command and parameter bytes use bits [7:0].
REQ-008 Port mlcd_data_out  out  16  read data; mlcd_data_oe  out  1  bus drive enable.
REQ-009 Port pix_valid  out  1; pix_ready  in  1; pix_x  out  10; pix_y  out  10; pix_data  out  16 (RGB565).
REQ-010 Port disp_on  out  1  display-on flag; pix_ovf  out  1  sticky pixel-drop flag.

Function
REQ-011 Two-flop synchronizers SHALL be applied to cs_n, wr_n and rd_n; rs and data SHALL be sampled at the write-strobe event.
REQ-012 A write event SHALL be a synchronized wr_n rising edge while synchronized cs_n=0, 3 sys_clk after the pin edge; the host holds each strobe phase for at least 4 sys_clk.
REQ-013 A write with rs=0 SHALL be a command, SHALL abort any sequence in progress, and SHALL select the next state.
REQ-014 States SHALL be IDLE, CASET, PASET, RAMWR and RDID; a 2-bit parameter counter SHALL be cleared on every command.
REQ-015 Command 0x2A SHALL enter CASET: 4 parameter writes give SC[15:8], SC[7:0], EC[15:8], EC[7:0]; the 4th write returns to IDLE.
REQ-016 Command 0x2B SHALL enter PASET and load SP/EP the same way as CASET.
REQ-017 Command 0x2C SHALL enter RAMWR and set cursor x=SC, y=SP.
REQ-018 Commands 0x29 and 0x28 SHALL set and clear disp_on respectively, then go to IDLE; 0xD3 SHALL enter RDID; any other command SHALL go to IDLE.
REQ-019 Window limits SHALL be clamped to H_RES-1 and V_RES-1 when loaded; if start>end after clamping, end SHALL equal start.
REQ-020 In RAMWR, each rs=1 write SHALL present (x,y,data) and advance the cursor: x++; at x=EC, x=SC and y++; at y=EP, y=SP.
REQ-021 Pixel output SHALL use a one-entry holding register: pix_valid rises the cycle after the write event and holds until pix_valid&pix_ready.
REQ-022 A pixel arriving while the holding register is occupied and pix_ready=0 SHALL be dropped with pix_ovf=1; the cursor SHALL still advance.
REQ-023 A pixel arriving in the same cycle the held pixel is accepted SHALL be loaded, not dropped.
REQ-024 Parameter writes in IDLE SHALL be ignored; chip-select toggling SHALL NOT change state.
REQ-025 If wr_n and rd_n are both low, both SHALL be ignored.

Reset
REQ-026 On sys_rst: state=IDLE, SC=SP=0, EC=H_RES-1, EP=V_RES-1, cursor=0, pix_valid=0, pix_ovf=0, disp_on=0, mlcd_data_oe=0, mlcd_data_out=0, pix_x=pix_y=pix_data=0.
REQ-027 Reset in the middle of a RAMWR or parameter sequence SHALL discard any held pixel and partial parameter.

Configuration
REQ-028 With MLCD_READ_EN defined: in RDID, each synchronized rd_n falling edge with cs_n=0 SHALL drive successive words 0x0000, 0x0000, ID_CODE[15:8], ID_CODE[7:0], then repeat the last word; mlcd_data_oe = synced(~cs_n & ~rd_n).
REQ-029 Without MLCD_READ_EN: 0xD3 SHALL behave as an unknown command, mlcd_data_oe SHALL be constant 0, and mlcd_data_out SHALL be constant 0.

Structure
REQ-030 A shared package mlcd_pkg SHALL hold the command opcodes (0x2A, 0x2B, 0x2C, 0x28, 0x29, 0xD3) and the state enumeration.
REQ-031 A sub-module mlcd_sync SHALL implement the synchronizer and edge detect for one strobe and SHALL be instantiated three times.

Verification
REQ-032 CASET 0,0,0,9; PASET 0,0,0,1; RAMWR; 21 pixels with pix_ready=1 -> pixels at (0..9,0), then (0..9,1), then the 21st at (0,0).
REQ-033 CASET 0,0,0x01,0x2C (EC=300) -> EC clamps to 239; a RAMWR run wraps from x=239 back to SC.
REQ-034 pix_ready=0 during two RAMWR pixels A and B -> A held, B dropped, pix_ovf=1; pix_ready=1 -> A accepted, pix_ovf stays 1.
REQ-035 With MLCD_READ_EN: 0xD3, then four reads -> 0x0000, 0x0000, 0x0093, 0x0041; oe is high only while rd_n is low.
REQ-036 sys_rst asserted after 5 of 10 RAMWR pixels -> pix_valid=0 the next cycle; following parameter writes are ignored; the window returns to full screen.
REQ-037 0x29 -> disp_on=1; 0x28 -> disp_on=0; CASET aborted after 2 parameters by 0x2C -> SC unchanged, RAMWR starts at the old SC.
